// File: rtl/pipelined_flag_alu_pkg.sv
// Shared types for the pipelined flag ALU: opcode enum, flag bundle and opcode classifier.
package pipelined_flag_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_ADC = 3'b110,
    OP_SBC = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational execute stage: result and C/V/N/Z flags for one op.
// PIPELINED_FLAG_ALU_SATURATE_EN clamps overflowing arithmetic results to signed max/min.
module alu_exec_unit
  import pipelined_flag_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic             sub;
  logic             carry_in;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  always_comb begin
    sub      = (op == OP_SUB) || (op == OP_SBC);
    b_eff    = sub ? ~b : b;
    carry_in = 1'b0;
    case (op)
      OP_SUB:  carry_in = 1'b1;
      OP_ADC:  carry_in = cin;
      OP_SBC:  carry_in = ~cin;
      default: carry_in = 1'b0;
    endcase
    // Subtraction runs through the same adder as A + ~B + ~borrow_in.
    sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    result = '0;
    flags  = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        result  = sum[WIDTH-1:0];
        flags.c = sub ? ~sum[WIDTH] : sum[WIDTH];
        flags.v = ovf;
`ifdef PIPELINED_FLAG_ALU_SATURATE_EN
        // Overflow direction follows the common operand sign.
        if (ovf) result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
        result = sum[WIDTH-1:0];
`endif
        flags.n = result[WIDTH-1];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
    flags.z = (result == '0);
  end

endmodule

// File: rtl/pipelined_flag_alu.sv
// Two-stage pipelined ALU with stored carry and sticky overflow.
// Optional PIPELINED_FLAG_ALU_SATURATE_EN is implemented inside alu_exec_unit.
module pipelined_flag_alu
  import pipelined_flag_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_v,
  output logic             out_n,
  output logic             out_z,
  output logic             carry_flag,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  // Handshake: a beat moves whenever valid && ready on that edge; a stalled
  // output holds all out_* stable, and each stage takes data when the one
  // downstream is empty or draining in the same cycle.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic             s2_ready;
  logic             s1_move;
  logic [WIDTH-1:0] exec_result;
  alu_flags_t       exec_flags;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign s1_move  = s1_valid && s2_ready;

  alu_exec_unit #(.WIDTH(WIDTH)) u_exec (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .cin    (carry_flag),
    .result (exec_result),
    .flags  (exec_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= alu_op_e'(in_op);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
      out_n      <= 1'b0;
      out_z      <= 1'b0;
      carry_flag <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= exec_result;
        out_c      <= exec_flags.c;
        out_v      <= exec_flags.v;
        out_n      <= exec_flags.n;
        out_z      <= exec_flags.z;
        // ADC/SBC consumed the old carry this cycle, so chains need no bubble.
        if (is_arith(s1_op)) carry_flag <= exec_flags.c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       ovf_sticky <= 1'b0;
    else if (s1_move && exec_flags.v) ovf_sticky <= 1'b1;
    else if (ovf_clr)              ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_pipelined_flag_alu.sv
// Scoreboard bench for pipelined_flag_alu (WIDTH=16): directed cases, backpressure, random traffic, reset.
module tb_pipelined_flag_alu;
  import pipelined_flag_alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_c, out_v, out_n, out_z;
  logic         carry_flag;
  logic         ovf_sticky;
  logic         ovf_clr;

  logic [W+3:0] exp_q[$];
  logic [W+3:0] exp_item;
  int           errors = 0;
  int           checks = 0;
  logic         m_carry;
  logic         rand_bp = 1'b0;

  pipelined_flag_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_c(out_c), .out_v(out_v), .out_n(out_n), .out_z(out_z),
    .carry_flag(carry_flag), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic, evaluated in issue order.
  task automatic model_push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, sa, sb, us, ss, cin, maxs, mins;
    logic [W-1:0] res;
    logic c, v, n, arith;
    ua = longint'(a); ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    cin = longint'(m_carry);
    maxs = (longint'(1) << (W-1)) - 1;
    mins = -(longint'(1) << (W-1));
    c = 1'b0; v = 1'b0; arith = 1'b1; us = 0; ss = 0;
    case (op)
      3'b000: begin us = ua + ub;       ss = sa + sb;       c = (us >= (longint'(1) << W)); end
      3'b110: begin us = ua + ub + cin; ss = sa + sb + cin; c = (us >= (longint'(1) << W)); end
      3'b001: begin us = ua - ub;       ss = sa - sb;       c = (ua < ub); end
      3'b111: begin us = ua - ub - cin; ss = sa - sb - cin; c = (ua < ub + cin); end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      res = us[W-1:0];
      v = (ss > maxs) || (ss < mins);
`ifdef PIPELINED_FLAG_ALU_SATURATE_EN
      if (v) res = (ss > maxs) ? maxs[W-1:0] : mins[W-1:0];
`endif
      n = res[W-1];
      m_carry = c;
    end else begin
      case (op)
        3'b010:  res = a & b;
        3'b011:  res = a | b;
        3'b100:  res = a ^ b;
        default: res = ~a;
      endcase
      n = 1'b0;
    end
    exp_q.push_back({res, c, v, n, (res == '0)});
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("issue_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    model_push(op, a, b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    rand_bp = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // random consumer backpressure, changed well away from both edges
  always @(posedge clk) begin
    #2;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        exp_item = exp_q.pop_front();
        check("out", {out_result, out_c, out_v, out_n, out_z}, exp_item);
      end
    end
  end

  initial begin
    int acc;
    int seen;
    logic [2:0]   cop;
    logic [W-1:0] ca, cb;
    logic [W+4:0] held;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; ovf_clr = 1'b0; m_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result_flags", {out_result, out_c, out_v, out_n, out_z}, 0);
    check("rst_carry_sticky", {carry_flag, ovf_sticky}, 0);

    // positive overflow and 2-cycle latency
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    check("lat_edge_k", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge_k1", out_valid, 1);
    check("sticky_set", ovf_sticky, 1);
    drain();

    // carry chain, borrow chain, logical op preserving carry
    issue(OP_ADD, 16'hFFFF, 16'h0001);
    issue(OP_ADC, 16'h0000, 16'h0000);
    drain();
    check("adc_chain_carry", carry_flag, 0);
    issue(OP_SUB, 16'h0000, 16'h0001);
    issue(OP_SBC, 16'h0005, 16'h0001);
    drain();
    check("sbc_chain_carry", carry_flag, 0);
    issue(OP_ADD, 16'hFFFF, 16'h0001);
    issue(OP_NOT, 16'hFFFF, 16'h0000);
    drain();
    check("not_keeps_carry", carry_flag, 1);

    // backpressure: only two ops fit while the output is stalled
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    cop = 3'($urandom_range(0, 7)); ca = W'($urandom); cb = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = cop; in_a = ca; in_b = cb;
      if (in_ready) begin
        model_push(cop, ca, cb);
        acc++;
        cop = 3'($urandom_range(0, 7)); ca = W'($urandom); cb = W'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", acc, 2);
    check("bp_in_ready", in_ready, 0);
    held = {out_valid, out_result, out_c, out_v, out_n, out_z};
    repeat (3) @(negedge clk);
    check("bp_stable", {out_valid, out_result, out_c, out_v, out_n, out_z}, held);
    drain();

    // random traffic with random consumer stalls
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    drain();
    check("rand_carry", carry_flag, m_carry);

    // clear, then clear colliding with an overflowing transfer
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("sticky_clear", ovf_sticky, 0);
    issue(OP_SUB, 16'h8000, 16'h0001);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    check("sticky_set_wins", ovf_sticky, 1);
    drain();

    // reset with two ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0002);
    issue(OP_XOR, 16'h0003, 16'h0005);
    check("inflight_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_carry = 1'b0;
    check("midrst_outputs", {out_valid, out_result, out_c, out_v, out_n, out_z}, 0);
    check("midrst_flags", {carry_flag, ovf_sticky}, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_out_after_rst", seen, 0);
    issue(OP_ADD, 16'h1234, 16'h0FF0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_flag_alu.md
Name: pipelined_flag_alu

Overview:
Parametrised, 2-stage pipelined ALU with valid/ready handshakes on both sides.
- Ops: ADD, SUB, AND, OR, XOR, NOT, ADC, SBC.
- Outputs: full C/V/N/Z flags, a stored carry flag for multi-word arithmetic, and a sticky overflow flag.
- Sits between the operand-issue logic and the writeback stage of the datapath; replaces the fixed 16-bit combinational ALU.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 4..64.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  stage 1 can accept.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode (see Behaviour).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts.
- out_result  output  WIDTH  result.
- out_c  output  1  carry (ADD/ADC) or borrow (SUB/SBC).
- out_v  output  1  signed overflow.
- out_n  output  1  sign, result[WIDTH-1].
- out_z  output  1  result == 0.
- carry_flag  output  1  stored carry/borrow register.
- ovf_sticky  output  1  sticky overflow.
- ovf_clr  input  1  single-cycle clear of ovf_sticky.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: ~A.
  - 110 ADC: A+B+carry_flag.
  - 111 SBC: A-B-carry_flag.
- Arithmetic:
  - Computed at WIDTH+1 bits.
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBC: C = borrow, i.e. 1 when unsigned A < B+cin; implement as A+~B+~cin, then C = ~carry_out.
  - V = signed overflow (operand sign bits equal, result sign differs; for SUB/SBC compare against ~B).
- Logical ops: C=V=N=0; Z from the result.
- Stage 1: operand register (a, b, op, s1_valid).
- Stage 2: execute plus result/flag register (out_*).
- Ready chain:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready.
  - Full throughput: one op per cycle when unstalled.
- Latency: 2 cycles. An op accepted at edge k appears with out_valid=1 after edge k+1.
- Handshake rules:
  - Transfer occurs when valid && ready.
  - Outputs hold stable while out_valid && !out_ready.
  - Ops never reorder or drop.
- carry_flag:
  - Updated with C at the edge an arithmetic op (000, 001, 110, 111) moves s1->s2.
  - Logical ops leave it unchanged.
  - ADC/SBC read carry_flag at that same transfer, so back-to-back ADC chains are correct without bubbles.
- ovf_sticky:
  - Set at the s1->s2 transfer of any op with V=1.
  - Cleared by ovf_clr.
  - Simultaneous set and clear: set wins (ends at 1).
- Reset: all state 0 (s1_valid, out_valid, out_result, all flags, carry_flag, ovf_sticky); in_ready=1 once rst deasserts.
- Reset mid-operation: in-flight ops are discarded, with no output after deassertion.

Optional Feature:
- Macro: PIPELINED_FLAG_ALU_SATURATE_EN.
- Defined: ADD/SUB/ADC/SBC results with V=1 clamp to the signed max (0111..1) on positive overflow, or the signed min (1000..0) on negative overflow.
  - V, C and ovf_sticky are still reported from the unsaturated computation.
  - N and Z reflect the clamped result.
- Undefined: results wrap modulo 2^WIDTH.

Decomposition:
- Package pipelined_flag_alu_pkg:
  - alu_op_e typedef enum logic [2:0] (OP_ADD..OP_SBC).
  - alu_flags_t packed struct {c, v, n, z}.
  - is_arith() function.
- Sub-module alu_exec_unit #(WIDTH): purely combinational (a, b, op, cin) -> (result, flags); holds the saturation logic under the macro.
- Top: pipeline registers, handshake, carry_flag, ovf_sticky.

Test Plan (WIDTH=16):
1. ADD 0x7FFF+0x0001 -> out_result 0x8000, V=1, N=1, C=0, Z=0; out_valid 2 cycles after accept; ovf_sticky=1. With SATURATE_EN: out_result 0x7FFF, N=0.
2. ADD 0xFFFF+0x0001, then ADC 0x0000+0x0000 back-to-back -> 0x0000 (C=1, Z=1), then 0x0001 (C=0); carry_flag ends 0.
3. SUB 0x0000-0x0001 -> 0xFFFF, C=1, N=1, V=0; following SBC 0x0005-0x0001 -> 0x0003, C=0.
4. NOT 0xFFFF after a C=1 op -> 0x0000, Z=1, C=V=N=0; carry_flag remains 1.
5. Backpressure: out_ready=0, in_valid=1 for 4 cycles -> exactly 2 ops accepted, then in_ready=0; out_* stable. Raise out_ready -> results emerge in issue order, one per cycle.
6. ovf_clr in the same cycle as an overflowing op's s1->s2 transfer -> ovf_sticky=1. Assert rst with 2 ops in flight -> all outputs 0 immediately; no results after release.
